// File: rtl/exception_unit_pkg.sv
// Shared definitions for the exception sequencer and the memory-address mux:
// select codes, vector addresses, cause and state encodings.
package exception_unit_pkg;

    localparam logic [2:0] SEL_PC     = 3'd0;
    localparam logic [2:0] SEL_ALUOUT = 3'd1;
    localparam logic [2:0] SEL_NOOP   = 3'd2;
    localparam logic [2:0] SEL_OVF    = 3'd3;
    localparam logic [2:0] SEL_DIV0   = 3'd4;

    localparam logic [7:0] VEC_NOOP = 8'd253;
    localparam logic [7:0] VEC_OVF  = 8'd254;
    localparam logic [7:0] VEC_DIV0 = 8'd255;

    localparam logic [31:0] EPC_ADJUST = 32'd4;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } state_e;

    // Vector address the mux presents for a select code; non-vector codes give 0.
    function automatic logic [7:0] sel_to_vector(input logic [2:0] sel);
        case (sel)
            SEL_NOOP: return VEC_NOOP;
            SEL_OVF:  return VEC_OVF;
            SEL_DIV0: return VEC_DIV0;
            default:  return 8'd0;
        endcase
    endfunction

    // Handler addresses are a single byte fetched from the vector slot.
    function automatic logic [31:0] handler_addr(input logic [7:0] vec_byte);
        return {24'b0, vec_byte};
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Bundle between the control FSM / datapath and the exception sequencer.
// slave is the sequencer side, master is the control/datapath side.
interface exception_unit_if;
    import exception_unit_pkg::*;

    logic [2:0]  ctrl_src_add_mem;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div0;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;

    logic [2:0]  src_add_mem;
    logic        epc_write;
    logic [31:0] epc_out;
    logic        pc_write;
    logic [31:0] pc_out;
    logic        busy;
    cause_e      cause;

    modport slave (
        input  ctrl_src_add_mem, exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
        output src_add_mem, epc_write, epc_out, pc_write, pc_out, busy, cause
    );

    modport master (
        output ctrl_src_add_mem, exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
        input  src_add_mem, epc_write, epc_out, pc_write, pc_out, busy, cause
    );

endinterface

// File: rtl/exc_priority.sv
// Fixed-priority trap encoder: div0 beats overflow beats invalid opcode.
module exc_priority
    import exception_unit_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic       trap,
    output cause_e     cause,
    output logic [2:0] vec_sel
);

    // NOTE: every output gets a default first so no path through the
    // if-chain leaves a value unassigned and infers a latch.
    always_comb begin
        trap    = 1'b1;
        cause   = CAUSE_NONE;
        vec_sel = SEL_PC;
        if (exc_div0) begin
            cause   = CAUSE_DIV0;
            vec_sel = SEL_DIV0;
        end else if (exc_overflow) begin
            cause   = CAUSE_OVF;
            vec_sel = SEL_OVF;
        end else if (exc_opcode) begin
            cause   = CAUSE_OPCODE;
            vec_sel = SEL_NOOP;
        end else begin
            trap = 1'b0;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception entry sequencer: captures a trap, saves EPC, fetches the handler
// byte through the vector slot and loads it into PC, stalling control meanwhile.
module exception_unit
    import exception_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    exception_unit_if.slave bus
);

    state_e     state;
    cause_e     cause_q;
    logic [2:0] vec_sel_q;

    logic       trap_any;
    cause_e     trap_cause;
    logic [2:0] trap_vec;

    // Only the low byte of the vector slot carries the handler address.
    logic unused_mem_hi;
    assign unused_mem_hi = ^bus.mem_data_in[31:8];

    exc_priority u_priority (
        .exc_opcode   (bus.exc_opcode),
        .exc_overflow (bus.exc_overflow),
        .exc_div0     (bus.exc_div0),
        .trap         (trap_any),
        .cause        (trap_cause),
        .vec_sel      (trap_vec)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            vec_sel_q <= SEL_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Traps are only looked at here; later requests wait for IDLE.
                    if (trap_any) begin
                        cause_q   <= trap_cause;
                        vec_sel_q <= trap_vec;
                        state     <= ST_SAVE;
                    end
                end
                ST_SAVE: state <= ST_WAIT;
                ST_WAIT: state <= ST_LOAD;
                ST_LOAD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.src_add_mem = bus.ctrl_src_add_mem;
        bus.epc_write   = 1'b0;
        bus.epc_out     = 32'd0;
        bus.pc_write    = 1'b0;
        bus.pc_out      = 32'd0;
        bus.busy        = 1'b0;
        case (state)
            ST_SAVE: begin
                bus.src_add_mem = vec_sel_q;
                bus.epc_write   = 1'b1;
                bus.epc_out     = bus.pc_in - EPC_ADJUST;
                bus.busy        = 1'b1;
            end
            ST_WAIT: begin
                // Vector read issued from SAVE is in flight; keep the address stable.
                bus.src_add_mem = vec_sel_q;
                bus.busy        = 1'b1;
            end
            ST_LOAD: begin
                bus.src_add_mem = vec_sel_q;
                bus.pc_write    = 1'b1;
                bus.pc_out      = handler_addr(bus.mem_data_in[7:0]);
                bus.busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cause = cause_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit.
module tb_exception_unit;
    import exception_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exception_unit_if bus ();

    exception_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset                = 1'b1;
        bus.ctrl_src_add_mem = SEL_ALUOUT;
        bus.exc_opcode       = 1'b0;
        bus.exc_overflow     = 1'b0;
        bus.exc_div0         = 1'b0;
        bus.pc_in            = 32'h0;
        bus.mem_data_in      = 32'h0;
        tick();
        tick();
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_cause", {30'b0, bus.cause}, 32'd0);
        check("rst_epc_write", {31'b0, bus.epc_write}, 32'd0);
        check("rst_pc_write", {31'b0, bus.pc_write}, 32'd0);
        check("rst_epc_out", bus.epc_out, 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_src", {29'b0, bus.src_add_mem}, 32'd1);
        reset = 1'b0;
        tick();

        // Overflow trap, one-cycle pulse
        bus.exc_overflow = 1'b1;
        bus.pc_in        = 32'h40;
        bus.mem_data_in  = 32'h0000_0080;
        #1;
        check("ovf_idle_src", {29'b0, bus.src_add_mem}, 32'd1);
        tick();
        bus.exc_overflow = 1'b0;
        #1;
        check("ovf_save_src", {29'b0, bus.src_add_mem}, 32'd3);
        check("ovf_save_epcw", {31'b0, bus.epc_write}, 32'd1);
        check("ovf_save_epc", bus.epc_out, 32'h3C);
        check("ovf_save_busy", {31'b0, bus.busy}, 32'd1);
        check("ovf_save_pcw", {31'b0, bus.pc_write}, 32'd0);
        check("ovf_cause", {30'b0, bus.cause}, 32'd2);
        tick();
        check("ovf_wait_src", {29'b0, bus.src_add_mem}, 32'd3);
        check("ovf_wait_busy", {31'b0, bus.busy}, 32'd1);
        check("ovf_wait_epcw", {31'b0, bus.epc_write}, 32'd0);
        check("ovf_wait_pcw", {31'b0, bus.pc_write}, 32'd0);
        tick();
        check("ovf_load_src", {29'b0, bus.src_add_mem}, 32'd3);
        check("ovf_load_busy", {31'b0, bus.busy}, 32'd1);
        check("ovf_load_pcw", {31'b0, bus.pc_write}, 32'd1);
        check("ovf_load_pc", bus.pc_out, 32'h80);
        tick();
        check("ovf_done_busy", {31'b0, bus.busy}, 32'd0);
        check("ovf_done_pcw", {31'b0, bus.pc_write}, 32'd0);
        check("ovf_done_src", {29'b0, bus.src_add_mem}, 32'd1);
        check("ovf_cause_hold", {30'b0, bus.cause}, 32'd2);

        // All traps together: div0 wins, upper data bits dropped
        bus.exc_opcode   = 1'b1;
        bus.exc_overflow = 1'b1;
        bus.exc_div0     = 1'b1;
        bus.pc_in        = 32'h100;
        bus.mem_data_in  = 32'hFFFF_FF10;
        tick();
        bus.exc_opcode   = 1'b0;
        bus.exc_overflow = 1'b0;
        bus.exc_div0     = 1'b0;
        #1;
        check("all_src", {29'b0, bus.src_add_mem}, 32'd4);
        check("all_cause", {30'b0, bus.cause}, 32'd3);
        check("all_epc", bus.epc_out, 32'hFC);
        tick();
        tick();
        check("all_load_pc", bus.pc_out, 32'h10);
        check("all_load_src", {29'b0, bus.src_add_mem}, 32'd4);
        tick();

        // Opcode trap with PC = 0: EPC wraps
        bus.exc_opcode = 1'b1;
        bus.pc_in      = 32'h0;
        tick();
        bus.exc_opcode = 1'b0;
        #1;
        check("op_epc_wrap", bus.epc_out, 32'hFFFF_FFFC);
        check("op_src", {29'b0, bus.src_add_mem}, 32'd2);
        check("op_cause", {30'b0, bus.cause}, 32'd1);
        tick();
        tick();
        tick();

        // Idle pass-through of every select code
        for (int i = 0; i < 8; i++) begin
            bus.ctrl_src_add_mem = 3'(i);
            #1;
            check("pass_src", {29'b0, bus.src_add_mem}, 32'(i));
            check("pass_busy", {31'b0, bus.busy}, 32'd0);
            tick();
        end
        check("pass_cause_hold", {30'b0, bus.cause}, 32'd1);

        // div0 re-raised mid-entry is ignored until IDLE
        bus.ctrl_src_add_mem = SEL_PC;
        bus.pc_in            = 32'h200;
        bus.mem_data_in      = 32'h0000_0020;
        bus.exc_div0         = 1'b1;
        tick();
        bus.exc_div0 = 1'b0;
        #1;
        check("rd_save_epcw", {31'b0, bus.epc_write}, 32'd1);
        tick();
        bus.exc_div0 = 1'b1;
        #1;
        check("rd_wait_busy", {31'b0, bus.busy}, 32'd1);
        check("rd_wait_epcw", {31'b0, bus.epc_write}, 32'd0);
        tick();
        check("rd_load_pcw", {31'b0, bus.pc_write}, 32'd1);
        check("rd_load_pc", bus.pc_out, 32'h20);
        tick();
        check("rd_idle_busy", {31'b0, bus.busy}, 32'd0);
        check("rd_idle_src", {29'b0, bus.src_add_mem}, 32'd0);
        tick();
        bus.exc_div0 = 1'b0;
        #1;
        check("rd_second_save", {31'b0, bus.epc_write}, 32'd1);
        check("rd_second_src", {29'b0, bus.src_add_mem}, 32'd4);
        tick();
        tick();
        tick();
        check("rd_second_done", {31'b0, bus.busy}, 32'd0);

        // Reset during WAIT aborts the entry
        bus.exc_overflow = 1'b1;
        bus.pc_in        = 32'h300;
        bus.mem_data_in  = 32'h0000_0044;
        tick();
        bus.exc_overflow = 1'b0;
        tick();
        check("rw_in_wait", {31'b0, bus.busy}, 32'd1);
        reset                = 1'b1;
        bus.ctrl_src_add_mem = 3'd5;
        tick();
        check("rw_busy", {31'b0, bus.busy}, 32'd0);
        check("rw_cause", {30'b0, bus.cause}, 32'd0);
        check("rw_pcw", {31'b0, bus.pc_write}, 32'd0);
        check("rw_pc_out", bus.pc_out, 32'h0);
        check("rw_src", {29'b0, bus.src_add_mem}, 32'd5);
        reset = 1'b0;
        tick();
        check("rw_after_pcw", {31'b0, bus.pc_write}, 32'd0);
        check("rw_after_busy", {31'b0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
